instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer handing fetched words to decode with valid/ready; define FETCH_BOUND_CHECK_EN for the out-of-range FAULT state
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);
`ifdef FETCH_BOUND_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_e;
`else
  typedef enum logic {BOOT, RUN} state_e;
`endif
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ifpc_q, ifpc_d, cnt_q, cnt_d;
  logic        valid_q, valid_d, advance;
  assign address     = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign fetch_count = cnt_q;
  assign advance     = !valid_q || id_ready;
`ifdef FETCH_BOUND_CHECK_EN
  logic fault_q, fault_d, oob, redirect_ok;
  assign fetch_fault = fault_q;
  assign oob         = pc_q >= 32'(MEM_DEPTH);
  assign redirect_ok = state_q != FAULT || redirect_target < 32'(MEM_DEPTH);
`else
  assign fetch_fault = 1'b0 & (pc_q >= 32'(MEM_DEPTH));
`endif
  // state register; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      cnt_q   <= '0;
`ifdef FETCH_BOUND_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      cnt_q   <= cnt_d;
`ifdef FETCH_BOUND_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end
  // next state: redirect squashes, otherwise boot delay, sequential fetch or stall
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    cnt_d   = cnt_q + {31'd0, valid_q & id_ready};
`ifdef FETCH_BOUND_CHECK_EN
    fault_d = fault_q;
    if (redirect) begin
      if (redirect_ok) begin
        pc_d    = redirect_target;
        valid_d = 1'b0;
        state_d = RUN;
        fault_d = 1'b0;
      end
    end else
`else
    if (redirect) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
      state_d = RUN;
    end else
`endif
    if (state_q == BOOT) state_d = RUN;
    else if (state_q == RUN && advance) begin
`ifdef FETCH_BOUND_CHECK_EN
      if (oob) begin
        state_d = FAULT;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end else
`endif
      begin
        instr_d = instruction;
        ifpc_d  = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus random traffic against a transaction-level fetch model
module tb_instruction_fetch;
  logic        clk = 1'b0, reset = 1'b1, redirect = 1'b0, id_ready = 1'b0;
  logic [31:0] redirect_target = '0, address, instruction, if_instr, if_pc, fetch_count;
  logic        if_valid, fetch_fault;
  int          errors = 0, checks = 0;
  logic [31:0] key;
`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ key;
  endfunction
  assign instruction = mem(address);
  instruction_fetch dut (
    .clk(clk), .reset(reset), .address(address), .instruction(instruction),
    .redirect(redirect), .redirect_target(redirect_target), .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_count(fetch_count), .fetch_fault(fetch_fault)
  );
  logic [31:0] m_pc, m_instr, m_ifpc, m_cnt;
  logic        m_valid, m_boot, m_fault;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_step();
    if (reset) begin
      m_pc = 32'd0; m_boot = 1'b1; m_valid = 1'b0; m_instr = '0; m_ifpc = '0; m_cnt = '0; m_fault = 1'b0;
    end else begin
      if (m_valid && id_ready) m_cnt = m_cnt + 1;
      if (redirect) begin
        if (!(m_fault && redirect_target >= 64)) begin
          m_pc = redirect_target; m_valid = 1'b0; m_boot = 1'b0; m_fault = 1'b0;
        end
      end else if (m_boot) m_boot = 1'b0;
      else if (!m_fault && (!m_valid || id_ready)) begin
        if (BC && m_pc >= 64) begin
          m_fault = 1'b1; m_valid = 1'b0;
        end else begin
          m_instr = mem(m_pc); m_ifpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 1;
        end
      end
    end
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("address", address, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("if_pc", if_pc, m_ifpc);
      chk("if_instr", if_instr, m_instr);
    end
    chk("fetch_count", fetch_count, m_cnt);
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  endtask
  initial begin
    key = $urandom;
    reset = 1'b1; id_ready = 1'b1;
    cyc();
    chk("rst_addr", address, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    reset = 1'b0;
    cyc();
    chk("boot_valid", {31'd0, if_valid}, 32'd0);
    chk("boot_addr", address, 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("seq_pc", if_pc, 32'(k));
      chk("seq_instr", if_instr, mem(32'(k)));
      chk("seq_valid", {31'd0, if_valid}, 32'd1);
    end
    cyc();
    chk("seq_count6", fetch_count, 32'd6);
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    for (int k = 0; k < 3; k++) cyc();
    chk("pre_stall_pc", if_pc, 32'd2);
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_pc", if_pc, 32'd2);
      chk("stall_instr", if_instr, mem(32'd2));
      chk("stall_addr", address, 32'd3);
      chk("stall_count", fetch_count, 32'd2);
    end
    id_ready = 1'b1;
    cyc();
    chk("release_pc", if_pc, 32'd3);
    cyc();
    chk("pre_redir_pc", if_pc, 32'd4);
    id_ready = 1'b0; redirect = 1'b1; redirect_target = 32'd40;
    cyc();
    chk("redir_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_addr", address, 32'd40);
    redirect = 1'b0; id_ready = 1'b1;
    cyc();
    chk("redir_pc", if_pc, 32'd40);
    chk("redir_vld", {31'd0, if_valid}, 32'd1);
    redirect = 1'b1; redirect_target = 32'd6;
    cyc();
    redirect = 1'b0;
    cyc();
    id_ready = 1'b0;
    cyc();
    chk("midrst_pre_addr", address, 32'd7);
    reset = 1'b1;
    cyc();
    chk("midrst_addr", address, 32'd0);
    chk("midrst_valid", {31'd0, if_valid}, 32'd0);
    chk("midrst_count", fetch_count, 32'd0);
    reset = 1'b0; id_ready = 1'b1;
    cyc();
    chk("midrst_boot", {31'd0, if_valid}, 32'd0);
    redirect = 1'b1; redirect_target = 32'd63;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("bnd_pc63", if_pc, 32'd63);
    chk("bnd_v63", {31'd0, if_valid}, 32'd1);
    cyc();
`ifdef FETCH_BOUND_CHECK_EN
    chk("bnd_fault", {31'd0, fetch_fault}, 32'd1);
    chk("bnd_valid", {31'd0, if_valid}, 32'd0);
    cyc();
    chk("bnd_hold", address, 32'd64);
`else
    chk("nobnd_fault", {31'd0, fetch_fault}, 32'd0);
    chk("nobnd_pc64", if_pc, 32'd64);
    chk("nobnd_valid", {31'd0, if_valid}, 32'd1);
`endif
    redirect = 1'b1; redirect_target = 32'd0;
    cyc();
    chk("bnd_clear", {31'd0, fetch_fault}, 32'd0);
    redirect = 1'b0;
    cyc();
    chk("bnd_pc0", if_pc, 32'd0);
`ifndef FETCH_BOUND_CHECK_EN
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFF);
    chk("wrap_addr", address, 32'd0);
`endif
    for (int k = 0; k < 400; k++) begin
      reset           = ($urandom_range(99) < 2);
      redirect        = ($urandom_range(99) < 10);
      redirect_target = 32'($urandom_range(70));
      id_ready        = ($urandom_range(99) < 70);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
